// File: rtl/uart_pattern_cmd.sv
// Parses "P<hex><CR>" commands from the UART byte stream, holds the new pattern
// index as pending until the next frame start, and acknowledges each command.
module uart_pattern_cmd #(
    parameter int TIMEOUT_CLKS = 2500000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    input  logic       i_TX_Active,
    input  logic       i_VSync,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    output logic [3:0] o_Pattern,
    output logic       o_Pending,
    output logic       o_Cmd_Error
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_GOT_P     = 2'd1;
    localparam logic [1:0] S_GOT_DIGIT = 2'd2;
    localparam logic [1:0] S_REPLY     = 2'd3;

    localparam int CNT_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 1);

    localparam logic [7:0] ACK_BYTE = 8'h4B;
    localparam logic [7:0] ERR_BYTE = 8'h45;

    logic [1:0]       state_q, state_d;
    logic [3:0]       digit_q, digit_d;
    logic [3:0]       pend_idx_q, pend_idx_d;
    logic [3:0]       pattern_q, pattern_d;
    logic             pending_q, pending_d;
    logic             tx_dv_q, tx_dv_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [7:0]       reply_q, reply_d;
    logic             cmd_err_q, cmd_err_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             vsync_q;
    logic             frame_start;
    logic [4:0]       hex;

    // {valid, nibble} for an ASCII hex digit in either case
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        logic [4:0] r;
        r = 5'd0;
        if (b >= 8'h30 && b <= 8'h39) begin
            r = {1'b1, b[3:0]};
        end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
            r = {1'b1, b[3:0] + 4'd9};
        end
        return r;
    endfunction

    assign frame_start = i_VSync & ~vsync_q;
    assign hex         = hex_decode(i_RX_Byte);

    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        pend_idx_d = pend_idx_q;
        pattern_d  = pattern_q;
        pending_d  = pending_q;
        tx_dv_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        reply_d    = reply_q;
        cmd_err_d  = 1'b0;
        tmo_d      = '0;

        // Frame apply is evaluated first so a same-edge accept re-arms pending.
        if (frame_start && pending_q) begin
            pattern_d = pend_idx_q;
            pending_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (i_RX_DV && (i_RX_Byte == 8'h50 || i_RX_Byte == 8'h70)) begin
                    state_d = S_GOT_P;
                end
            end
            S_GOT_P: begin
                if (i_RX_DV) begin
                    if (hex[4]) begin
                        digit_d = hex[3:0];
                        state_d = S_GOT_DIGIT;
                    end else begin
                        reply_d   = ERR_BYTE;
                        cmd_err_d = 1'b1;
                        state_d   = S_REPLY;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_GOT_DIGIT: begin
                if (i_RX_DV) begin
                    if (i_RX_Byte == 8'h0D) begin
                        pend_idx_d = digit_q;
                        pending_d  = 1'b1;
                        reply_d    = ACK_BYTE;
                    end else begin
                        reply_d   = ERR_BYTE;
                        cmd_err_d = 1'b1;
                    end
                    state_d = S_REPLY;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                if (!i_TX_Active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = reply_q;
                    state_d   = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= S_IDLE;
            digit_q    <= 4'd0;
            pend_idx_q <= 4'd0;
            pattern_q  <= 4'd0;
            pending_q  <= 1'b0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            reply_q    <= 8'h00;
            cmd_err_q  <= 1'b0;
            tmo_q      <= '0;
            vsync_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            pend_idx_q <= pend_idx_d;
            pattern_q  <= pattern_d;
            pending_q  <= pending_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            reply_q    <= reply_d;
            cmd_err_q  <= cmd_err_d;
            tmo_q      <= tmo_d;
            vsync_q    <= i_VSync;
        end
    end

    assign o_TX_DV     = tx_dv_q;
    assign o_TX_Byte   = tx_byte_q;
    assign o_Pattern   = pattern_q;
    assign o_Pending   = pending_q;
    assign o_Cmd_Error = cmd_err_q;

endmodule

// File: tb/tb_uart_pattern_cmd.sv
// Directed bench for uart_pattern_cmd: command accept/reject, frame apply,
// timeout, transmitter back-pressure and reset in the middle of a reply.
module tb_uart_pattern_cmd;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_active = 1'b0;
    logic       vsync = 1'b0;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic [3:0] pattern;
    logic       pending;
    logic       cmd_err;

    int checks = 0;
    int failures = 0;
    int tx_count = 0;
    int err_count = 0;
    int tx_viol = 0;
    logic [7:0] last_tx = 8'h00;
    logic seen_c = 1'b0;
    int base_tx;
    int base_err;

    always #5 clk = ~clk;

    uart_pattern_cmd #(.TIMEOUT_CLKS(100)) dut (
        .i_Clk      (clk),
        .i_Rst_L    (rst_n),
        .i_RX_DV    (rx_dv),
        .i_RX_Byte  (rx_byte),
        .i_TX_Active(tx_active),
        .i_VSync    (vsync),
        .o_TX_DV    (tx_dv),
        .o_TX_Byte  (tx_byte),
        .o_Pattern  (pattern),
        .o_Pending  (pending),
        .o_Cmd_Error(cmd_err)
    );

    always @(negedge clk) begin
        if (tx_dv) begin
            tx_count++;
            last_tx = tx_byte;
            if (tx_active) tx_viol++;
        end
        if (cmd_err) err_count++;
        if (pattern == 4'hC) seen_c = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        rx_dv = 1'b1;
        rx_byte = b;
        @(posedge clk); #1;
        rx_dv = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_cmd(input string name, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 20);
        send_byte(b1, 20);
        send_byte(b2, 20);
        $display("cmd %s sent: %02h %02h %02h", name, b0, b1, b2);
    endtask

    task automatic frame_edge();
        @(posedge clk); #1;
        vsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vsync = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_pattern", {28'd0, pattern}, 32'd0);
        check_eq("rst_pending", {31'd0, pending}, 32'd0);
        check_eq("rst_tx_dv", {31'd0, tx_dv}, 32'd0);
        check_eq("rst_tx_byte", {24'd0, tx_byte}, 32'h00);
        check_eq("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // P3<CR> with exact strobe timing
        base_tx = tx_count;
        send_byte(8'h50, 20);
        send_byte(8'h33, 20);
        send_byte(8'h0D, 0);
        @(negedge clk);
        check_eq("p3_pending_after_cr", {31'd0, pending}, 32'd1);
        check_eq("p3_txdv_not_yet", {31'd0, tx_dv}, 32'd0);
        @(negedge clk);
        check_eq("p3_txdv_strobe", {31'd0, tx_dv}, 32'd1);
        check_eq("p3_tx_byte", {24'd0, tx_byte}, 32'h4B);
        @(negedge clk);
        check_eq("p3_txdv_one_cycle", {31'd0, tx_dv}, 32'd0);
        repeat (10) @(posedge clk);
        check_eq("p3_tx_count", tx_count - base_tx, 32'd1);
        check_eq("p3_pattern_before_frame", {28'd0, pattern}, 32'd0);
        @(posedge clk); #1;
        vsync = 1'b1;
        @(negedge clk);
        check_eq("p3_pattern_at_vsync_set", {28'd0, pattern}, 32'd0);
        @(negedge clk);
        check_eq("p3_pattern_applied", {28'd0, pattern}, 32'd3);
        check_eq("p3_pending_cleared", {31'd0, pending}, 32'd0);
        $display("frame applied: pattern=%0h", pattern);

        // pc<CR> then P5<CR> inside one frame: last command wins
        base_tx = tx_count;
        send_cmd("pc", 8'h70, 8'h63, 8'h0D);
        send_cmd("P5", 8'h50, 8'h35, 8'h0D);
        check_eq("two_acks", tx_count - base_tx, 32'd2);
        check_eq("two_acks_byte", {24'd0, last_tx}, 32'h4B);
        check_eq("two_pattern_held", {28'd0, pattern}, 32'd3);
        check_eq("two_pending", {31'd0, pending}, 32'd1);
        frame_edge();
        @(negedge clk);
        check_eq("two_pattern_last_wins", {28'd0, pattern}, 32'd5);
        check_eq("two_never_c", {31'd0, seen_c}, 32'd0);
        check_eq("two_pending_cleared", {31'd0, pending}, 32'd0);

        // Malformed commands and junk in IDLE
        base_tx = tx_count; base_err = err_count;
        send_byte(8'h50, 20);
        send_byte(8'h47, 20);
        $display("cmd PG sent");
        check_eq("pg_reply_count", tx_count - base_tx, 32'd1);
        check_eq("pg_reply_byte", {24'd0, last_tx}, 32'h45);
        check_eq("pg_err_pulse", err_count - base_err, 32'd1);
        check_eq("pg_pattern_kept", {28'd0, pattern}, 32'd5);
        check_eq("pg_pending_clear", {31'd0, pending}, 32'd0);
        base_tx = tx_count; base_err = err_count;
        send_cmd("P1X", 8'h50, 8'h31, 8'h58);
        check_eq("p1x_reply_count", tx_count - base_tx, 32'd1);
        check_eq("p1x_reply_byte", {24'd0, last_tx}, 32'h45);
        check_eq("p1x_err_pulse", err_count - base_err, 32'd1);
        check_eq("p1x_pending_clear", {31'd0, pending}, 32'd0);
        base_tx = tx_count; base_err = err_count;
        send_byte(8'h5A, 20);
        $display("byte Z sent");
        check_eq("z_no_reply", tx_count - base_tx, 32'd0);
        check_eq("z_no_err", err_count - base_err, 32'd0);

        // Timeout after a lone 'P'; following '7',CR must be ignored in IDLE
        base_tx = tx_count; base_err = err_count;
        send_byte(8'h50, 150);
        send_byte(8'h37, 20);
        send_byte(8'h0D, 20);
        $display("timeout sequence sent");
        check_eq("tmo_no_reply", tx_count - base_tx, 32'd0);
        check_eq("tmo_no_err", err_count - base_err, 32'd0);
        check_eq("tmo_no_pending", {31'd0, pending}, 32'd0);
        base_tx = tx_count;
        send_byte(8'h50, 90);
        send_byte(8'h32, 90);
        send_byte(8'h0D, 20);
        $display("cmd P2 sent with long gaps");
        check_eq("p2_reply_count", tx_count - base_tx, 32'd1);
        check_eq("p2_reply_byte", {24'd0, last_tx}, 32'h4B);
        check_eq("p2_pending", {31'd0, pending}, 32'd1);

        // Transmitter busy across the CR
        base_tx = tx_count;
        @(posedge clk); #1;
        tx_active = 1'b1;
        send_cmd("P9", 8'h50, 8'h39, 8'h0D);
        repeat (430) @(posedge clk);
        check_eq("busy_no_strobe", tx_count - base_tx, 32'd0);
        #1;
        tx_active = 1'b0;
        @(negedge clk);
        check_eq("busy_not_yet", {31'd0, tx_dv}, 32'd0);
        @(negedge clk);
        check_eq("busy_strobe", {31'd0, tx_dv}, 32'd1);
        check_eq("busy_byte", {24'd0, tx_byte}, 32'h4B);
        @(negedge clk);
        check_eq("busy_one_cycle", {31'd0, tx_dv}, 32'd0);
        check_eq("busy_total", tx_count - base_tx, 32'd1);

        // Reset while in REPLY with pending set
        @(posedge clk); #1;
        tx_active = 1'b1;
        send_cmd("PA", 8'h50, 8'h41, 8'h0D);
        check_eq("rr_pending_before", {31'd0, pending}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rr_tx_dv", {31'd0, tx_dv}, 32'd0);
        check_eq("rr_pending", {31'd0, pending}, 32'd0);
        check_eq("rr_pattern", {28'd0, pattern}, 32'd0);
        base_tx = tx_count;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tx_active = 1'b0;
        repeat (50) @(posedge clk);
        check_eq("rr_no_reply", tx_count - base_tx, 32'd0);
        frame_edge();
        @(negedge clk);
        check_eq("rr_pattern_after_frame", {28'd0, pattern}, 32'd0);

        check_eq("tx_never_while_active", tx_viol, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_pattern_cmd.md
# uart_pattern_cmd

Command parser between the UART receiver and the VGA test pattern generator. It decodes ASCII commands of the form `P<hex digit><CR>` from the received byte stream and holds the new pattern index as pending. The pending index is applied to the output only at the start of a video frame. Each completed or malformed command gets a one-byte acknowledge, sent through the UART transmitter handshake.

## Interface
Parameters:
- TIMEOUT_CLKS, 2500000, idle clocks allowed between bytes of one command (100 ms at 25 MHz); minimum 2.

Ports:
- i_Clk  in  1  system clock (25 MHz)
- i_Rst_L  in  1  reset; one clock; reset is asynchronous and active-low
- i_RX_DV  in  1  one-cycle strobe: i_RX_Byte valid
- i_RX_Byte  in  8  received byte
- i_TX_Active  in  1  UART transmitter busy
- i_VSync  in  1  VGA vertical sync from sync generator; high during active rows
- o_TX_DV  out  1  one-cycle strobe: send o_TX_Byte
- o_TX_Byte  out  8  reply byte: 0x4B 'K' (accepted) or 0x45 'E' (error)
- o_Pattern  out  4  pattern index to test pattern generator
- o_Pending  out  1  a new index is waiting for the frame boundary
- o_Cmd_Error  out  1  one-cycle pulse on a malformed command

## Operation
- All state changes on rising i_Clk; i_Rst_L low asynchronously clears everything.
- Reset values:
  - state IDLE
  - o_Pattern 0, o_Pending 0
  - o_TX_DV 0, o_TX_Byte 0x00
  - o_Cmd_Error 0
  - timeout counter 0, registered VSync 0
- States:
  - IDLE
    - i_RX_DV with 'P' (0x50) or 'p' (0x70) -> GOT_P.
    - Any other byte is ignored and produces no reply.
  - GOT_P
    - i_RX_DV with '0'-'9', 'A'-'F' or 'a'-'f': latch the nibble value into the digit register -> GOT_DIGIT.
    - Any other byte: reply 'E', pulse o_Cmd_Error -> REPLY.
  - GOT_DIGIT
    - i_RX_DV with CR (0x0D): pending index <= digit, o_Pending <= 1, reply 'K' -> REPLY.
    - Any other byte: reply 'E', pulse o_Cmd_Error -> REPLY.
  - REPLY
    - While i_TX_Active = 1: hold.
    - When i_TX_Active = 0: o_TX_DV <= 1 for one cycle, o_TX_Byte <= reply -> IDLE.
    - Bytes arriving in REPLY are dropped.
- Timeout (GOT_P and GOT_DIGIT only):
  - The counter clears on entry and on every i_RX_DV, and increments otherwise.
  - At TIMEOUT_CLKS-1 the block returns to IDLE: no reply, no error pulse, pending state unchanged.
  - The counter is held at 0 in IDLE and REPLY.
- Frame apply:
  - Frame start is detected as i_VSync = 1 with registered VSync = 0.
  - On that edge, if o_Pending = 1: o_Pattern <= pending index, o_Pending <= 0.
- New accept with pending already set: the pending index is overwritten (last command wins), and o_Pending stays 1.
- Accept and frame start on the same edge: the edge applies the old pending value if o_Pending was 1. The new index becomes pending and o_Pending is 1 after the edge.
- Reset mid-command or mid-reply:
  - Any partial command is discarded.
  - No o_TX_DV is issued after reset is released.
  - o_Pattern returns to 0.

## Timing
- CR strobe sampled at edge N: o_Pending = 1 and state = REPLY after edge N.
- With i_TX_Active = 0 at edge N+1: o_TX_DV is high for exactly the cycle after edge N+1.
- o_Pattern changes only on the frame-start edge, never mid-frame. Latency from CR to o_Pattern is up to one frame (420,000 clocks at 800x525).
- o_Cmd_Error is high for the single cycle after the edge that sampled the bad byte.
- o_TX_Byte stays stable from the o_TX_DV cycle until the next reply is loaded.
- At most one o_TX_DV per command. o_TX_DV is never asserted while i_TX_Active = 1.

## Test plan
- Reset, then send 'P','3',CR with gaps of 217×10 clocks -> 'K' strobe once, o_Pending=1, o_Pattern stays 0 until the next i_VSync rise, then becomes 3 and o_Pending=0.
- Send 'p','c',CR, then 'P','5',CR within one frame -> two 'K' replies; at the frame start o_Pattern=5 (last wins), and it never shows 0xC.
- Send 'P','G' -> 'E' reply and one o_Cmd_Error pulse, o_Pattern unchanged. Send 'P','1','X' -> 'E'. Send 'Z' in IDLE -> no reply.
- Send 'P' then nothing for TIMEOUT_CLKS (set to 100 in the bench) -> back to IDLE, no strobe. A following 'P','2',CR -> 'K'.
- Hold i_TX_Active=1 for 500 clocks around a CR -> o_TX_DV fires exactly one cycle after i_TX_Active falls, byte 0x4B.
- Assert i_Rst_L low while in REPLY with o_Pending=1 -> o_TX_DV, o_Pending and o_Pattern all 0, and no reply appears after release.
